// File: rtl/arb_serializer_2d_pkg.sv
// Shared types and the round-robin grant function for arb_serializer_2d.
// Combinational helpers only: no latency, no flow control of their own.
// The grant function scans at most RR_MAX_PORTS requesters.
package arb_serializer_2d_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int unsigned RR_MAX_PORTS = 64;
    localparam int unsigned RR_IDX_W     = 6;

    typedef struct packed {
        logic                any;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, wrapping at n (n need not be a power of two).
    function automatic rr_pick_t rr_next_grant(
        input logic [RR_MAX_PORTS-1:0] req,
        input int unsigned             ptr,
        input int unsigned             n
    );
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        idx = 0;
        for (int unsigned k = 0; k < RR_MAX_PORTS; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!res.any && req[idx[RR_IDX_W-1:0]]) begin
                    res.any = 1'b1;
                    res.idx = idx[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_serializer_2d_rr_arbiter.sv
// Round-robin arbiter: one-hot and encoded grant starting from prio_ptr.
// Purely combinational; en gates every grant (and therefore every recv_rdy).
// No backpressure state is kept here; the caller advances prio_ptr.
module rr_arbiter
    import arb_serializer_2d_pkg::*;
#(
    parameter  int N_INPUTS = 2,
    localparam int SRC_W    = $clog2(N_INPUTS)
) (
    input  logic [N_INPUTS-1:0] req,
    input  logic [SRC_W-1:0]    prio_ptr,
    input  logic                en,
    output logic [N_INPUTS-1:0] gnt_oh,
    output logic [SRC_W-1:0]    gnt_idx,
    output logic                any
);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_next_grant(RR_MAX_PORTS'(req), 32'(prio_ptr), N_INPUTS);
        any     = en & pick.any;
        gnt_idx = SRC_W'(pick.idx);
        gnt_oh  = '0;
        if (any) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_serializer_2d.sv
// Round-robin drain of N_INPUTS array ports into one tagged word stream.
// Latency: array accepted at edge t, entry 0 valid in cycle t+1; ENTRIES words per packet.
// Backpressure: send_rdy low freezes all outputs; ARB_SERIALIZER_2D_B2B_EN overlaps next accept with the last word.
module arb_serializer_2d
    import arb_serializer_2d_pkg::*;
#(
    parameter  int BIT_WIDTH = 32,
    parameter  int N_INPUTS  = 2,
    parameter  int ENTRIES   = 2,
    localparam int SRC_W     = $clog2(N_INPUTS),
    localparam int CNT_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [N_INPUTS-1:0][ENTRIES-1:0][BIT_WIDTH-1:0] recv_msg,
    input  logic [N_INPUTS-1:0]                             recv_val,
    output logic [N_INPUTS-1:0]                             recv_rdy,
    output logic [BIT_WIDTH-1:0]                            send_msg,
    output logic                                            send_val,
    input  logic                                            send_rdy,
    output logic [SRC_W-1:0]                                send_src,
    output logic                                            send_last
);

    state_e                             state_q, state_d;
    logic [SRC_W-1:0]                   prio_ptr_q, prio_ptr_d;
    logic [ENTRIES-1:0][BIT_WIDTH-1:0]  buf_q, buf_d;
    logic [SRC_W-1:0]                   src_q, src_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;

    logic             busy;
    logic             last;
    logic             arb_en;
    logic             recv_fire;
    logic [SRC_W-1:0] gnt_idx;

    assign busy = (state_q == BUSY);
    assign last = busy && (cnt_q == CNT_W'(ENTRIES - 1));

    // Reset masks the arbiter so no port sees ready while the block is held in reset.
`ifdef ARB_SERIALIZER_2D_B2B_EN
    assign arb_en = !reset && (!busy || (last && send_rdy));
`else
    assign arb_en = !reset && !busy;
`endif

    rr_arbiter #(
        .N_INPUTS (N_INPUTS)
    ) u_arb (
        .req      (recv_val),
        .prio_ptr (prio_ptr_q),
        .en       (arb_en),
        .gnt_oh   (recv_rdy),
        .gnt_idx  (gnt_idx),
        .any      (recv_fire)
    );

    always_comb begin
        state_d    = state_q;
        prio_ptr_d = prio_ptr_q;
        buf_d      = buf_q;
        src_d      = src_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            BUSY: begin
                if (send_rdy) begin
                    if (last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A recv fire can only occur when the arbiter is enabled, so this overrides the drain step.
        if (recv_fire) begin
            state_d    = BUSY;
            buf_d      = recv_msg[gnt_idx];
            src_d      = gnt_idx;
            cnt_d      = '0;
            prio_ptr_d = (gnt_idx == SRC_W'(N_INPUTS - 1)) ? '0 : gnt_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prio_ptr_q <= '0;
            buf_q      <= '0;
            src_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            prio_ptr_q <= prio_ptr_d;
            buf_q      <= buf_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        send_msg = '0;
        if (busy) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (cnt_q == CNT_W'(e)) begin
                    send_msg = buf_q[e];
                end
            end
        end
    end

    assign send_val  = busy;
    assign send_src  = busy ? src_q : '0;
    assign send_last = last;

    a_rdy_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(recv_rdy));
    a_rdy_has_val: assert property (@(posedge clk) disable iff (reset) (recv_rdy & ~recv_val) == '0);
    a_cnt_range: assert property (@(posedge clk) disable iff (reset) cnt_q <= CNT_W'(ENTRIES - 1));

endmodule

// File: tb/tb_arb_serializer_2d.sv
// Bench for arb_serializer_2d: vector table, hand sequences for reset/throughput/wrap, and a random run against a queue model.
module tb_arb_serializer_2d;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: N=2 E=4, B: N=3 E=1, C: N=3 E=3
    logic [1:0][3:0][W-1:0] a_msg;
    logic [1:0]             a_val, a_rdy;
    logic [W-1:0]           a_smsg;
    logic                   a_sval, a_srdy, a_ssrc, a_slast;

    logic [2:0][0:0][W-1:0] b_msg;
    logic [2:0]             b_val, b_rdy;
    logic [W-1:0]           b_smsg;
    logic                   b_sval, b_srdy, b_slast;
    logic [1:0]             b_ssrc;

    logic [2:0][2:0][W-1:0] c_msg;
    logic [2:0]             c_val, c_rdy;
    logic [W-1:0]           c_smsg;
    logic                   c_sval, c_srdy, c_slast;
    logic [1:0]             c_ssrc;

    arb_serializer_2d #(.BIT_WIDTH(W), .N_INPUTS(2), .ENTRIES(4)) u_dut_a (
        .clk(clk), .reset(reset), .recv_msg(a_msg), .recv_val(a_val), .recv_rdy(a_rdy),
        .send_msg(a_smsg), .send_val(a_sval), .send_rdy(a_srdy), .send_src(a_ssrc), .send_last(a_slast));

    arb_serializer_2d #(.BIT_WIDTH(W), .N_INPUTS(3), .ENTRIES(1)) u_dut_b (
        .clk(clk), .reset(reset), .recv_msg(b_msg), .recv_val(b_val), .recv_rdy(b_rdy),
        .send_msg(b_smsg), .send_val(b_sval), .send_rdy(b_srdy), .send_src(b_ssrc), .send_last(b_slast));

    arb_serializer_2d #(.BIT_WIDTH(W), .N_INPUTS(3), .ENTRIES(3)) u_dut_c (
        .clk(clk), .reset(reset), .recv_msg(c_msg), .recv_val(c_val), .recv_rdy(c_rdy),
        .send_msg(c_smsg), .send_val(c_sval), .send_rdy(c_srdy), .send_src(c_ssrc), .send_last(c_slast));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]   val;
        logic         srdy;
        logic [1:0]   rr;
        logic         sval;
        logic [W-1:0] msg;
        logic         src;
        logic         last;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic [1:0] v, input logic r, input logic [1:0] rr,
                        input logic sv, input logic [W-1:0] m, input logic s, input logic l);
        vec_t x;
        x.val = v; x.srdy = r; x.rr = rr; x.sval = sv; x.msg = m; x.src = s; x.last = l;
        tbl.push_back(x);
    endtask

    task automatic set_a_msgs(input logic [W-1:0] base0, input logic [W-1:0] base1);
        for (int e = 0; e < 4; e++) begin
            a_msg[0][e] = base0 + W'(e);
            a_msg[1][e] = base1 + W'(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] msg;
        logic [1:0]   src;
        logic         last;
    } word_t;

    task automatic random_run(input int ncyc);
        word_t      q[$];
        word_t      w;
        int         ptr;
        int         g;
        int         p;
        logic       idle_ok;
        logic [2:0] exp_rr;
        ptr = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                c_val[i] = ($urandom_range(0, 9) < 6);
                for (int e = 0; e < 3; e++) c_msg[i][e] = $urandom;
            end
            c_srdy = ($urandom_range(0, 9) < 7);
            #1;
            idle_ok = (q.size() == 0);
`ifdef ARB_SERIALIZER_2D_B2B_EN
            if (q.size() == 1 && c_srdy) idle_ok = 1'b1;
`endif
            g = -1;
            exp_rr = '0;
            if (idle_ok) begin
                for (int k = 0; k < 3; k++) begin
                    p = (ptr + k) % 3;
                    if (g < 0 && c_val[p]) g = p;
                end
            end
            if (g >= 0) exp_rr[g] = 1'b1;
            chk("c_recv_rdy", 64'(c_rdy), 64'(exp_rr));
            chk("c_send_val", 64'(c_sval), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("c_send_msg", 64'(c_smsg), 64'(q[0].msg));
                chk("c_send_src", 64'(c_ssrc), 64'(q[0].src));
                chk("c_send_last", 64'(c_slast), 64'(q[0].last));
                if (c_srdy) void'(q.pop_front());
            end
            if (g >= 0) begin
                for (int e = 0; e < 3; e++) begin
                    w.msg  = c_msg[g][e];
                    w.src  = 2'(g);
                    w.last = (e == 2);
                    q.push_back(w);
                end
                ptr = (g + 1) % 3;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first_acc, last_cyc, nwords, gaps, exp_span, exp_gaps;
        logic saw_bad;
        logic [1:0] exp_src;

        // --- reset state, inputs asserted to show recv_rdy is masked
        reset = 1'b1;
        set_a_msgs(32'h10, 32'hA0);
        a_val = 2'b11; a_srdy = 1'b1;
        for (int i = 0; i < 3; i++) b_msg[i][0] = 32'h300 + W'(i);
        b_val = 3'b111; b_srdy = 1'b1;
        c_msg = '0; c_val = 3'b111; c_srdy = 1'b1;
        @(negedge clk); #1;
        chk("rst_a_rdy", 64'(a_rdy), 64'(0));
        chk("rst_a_sval", 64'(a_sval), 64'(0));
        chk("rst_a_msg", 64'(a_smsg), 64'(0));
        chk("rst_a_src", 64'(a_ssrc), 64'(0));
        chk("rst_a_last", 64'(a_slast), 64'(0));
        chk("rst_b_rdy", 64'(b_rdy), 64'(0));
        chk("rst_b_sval", 64'(b_sval), 64'(0));
        chk("rst_c_rdy", 64'(c_rdy), 64'(0));
        chk("rst_c_sval", 64'(c_sval), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        a_val = '0; b_val = '0; c_val = '0;

        // --- vector table (last-word rows keep recv_val low so both builds agree)
        addv(2'b11, 1, 2'b01, 0, 32'h00, 0, 0);
        addv(2'b11, 1, 2'b00, 1, 32'h10, 0, 0);
        addv(2'b11, 0, 2'b00, 1, 32'h11, 0, 0);
        addv(2'b11, 0, 2'b00, 1, 32'h11, 0, 0);
        addv(2'b11, 1, 2'b00, 1, 32'h11, 0, 0);
        addv(2'b11, 1, 2'b00, 1, 32'h12, 0, 0);
        addv(2'b00, 1, 2'b00, 1, 32'h13, 0, 1);
        addv(2'b11, 1, 2'b10, 0, 32'h00, 0, 0);
        addv(2'b11, 1, 2'b00, 1, 32'hA0, 1, 0);
        addv(2'b11, 1, 2'b00, 1, 32'hA1, 1, 0);
        addv(2'b11, 1, 2'b00, 1, 32'hA2, 1, 0);
        addv(2'b00, 1, 2'b00, 1, 32'hA3, 1, 1);
        addv(2'b11, 1, 2'b01, 0, 32'h00, 0, 0);
        addv(2'b11, 1, 2'b00, 1, 32'h10, 0, 0);
        addv(2'b11, 1, 2'b00, 1, 32'h11, 0, 0);
        addv(2'b11, 1, 2'b00, 1, 32'h12, 0, 0);
        addv(2'b00, 1, 2'b00, 1, 32'h13, 0, 1);
        addv(2'b11, 1, 2'b10, 0, 32'h00, 0, 0);
        addv(2'b11, 1, 2'b00, 1, 32'hA0, 1, 0);
        addv(2'b11, 1, 2'b00, 1, 32'hA1, 1, 0);
        addv(2'b11, 1, 2'b00, 1, 32'hA2, 1, 0);
        addv(2'b00, 1, 2'b00, 1, 32'hA3, 1, 1);
        addv(2'b10, 1, 2'b10, 0, 32'h00, 0, 0);
        addv(2'b10, 1, 2'b00, 1, 32'hA0, 1, 0);
        addv(2'b10, 1, 2'b00, 1, 32'hA1, 1, 0);
        addv(2'b10, 1, 2'b00, 1, 32'hA2, 1, 0);
        addv(2'b00, 1, 2'b00, 1, 32'hA3, 1, 1);
        addv(2'b10, 1, 2'b10, 0, 32'h00, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            a_val  = tbl[i].val;
            a_srdy = tbl[i].srdy;
            #1;
            chk($sformatf("tbl%0d_rdy", i), 64'(a_rdy), 64'(tbl[i].rr));
            chk($sformatf("tbl%0d_sval", i), 64'(a_sval), 64'(tbl[i].sval));
            if (tbl[i].sval) begin
                chk($sformatf("tbl%0d_msg", i), 64'(a_smsg), 64'(tbl[i].msg));
                chk($sformatf("tbl%0d_src", i), 64'(a_ssrc), 64'(tbl[i].src));
                chk($sformatf("tbl%0d_last", i), 64'(a_slast), 64'(tbl[i].last));
            end
        end

        // --- asynchronous reset after entry 1, then a fresh packet
        @(negedge clk);
        reset = 1'b1; a_val = '0;
        @(negedge clk);
        reset = 1'b0;
        set_a_msgs(32'h40, 32'hB0);
        a_val = 2'b01; a_srdy = 1'b1;
        #1;
        chk("ar_accept_rdy", 64'(a_rdy), 64'(2'b01));
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            a_val = '0;
            #1;
            chk($sformatf("ar_pre_msg%0d", e), 64'(a_smsg), 64'(32'h40 + e));
        end
        #2;
        a_val = 2'b01;
        reset = 1'b1;
        #1;
        chk("ar_async_sval", 64'(a_sval), 64'(0));
        chk("ar_async_rdy", 64'(a_rdy), 64'(0));
        chk("ar_async_msg", 64'(a_smsg), 64'(0));
        chk("ar_async_src", 64'(a_ssrc), 64'(0));
        chk("ar_async_last", 64'(a_slast), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        set_a_msgs(32'h50, 32'hC0);
        a_val = 2'b01;
        #1;
        chk("ar_new_rdy", 64'(a_rdy), 64'(2'b01));
        @(negedge clk);
        a_val = '0;
        for (int e = 0; e < 4; e++) begin
            #1;
            chk($sformatf("ar_new_msg%0d", e), 64'(a_smsg), 64'(32'h50 + e));
            chk($sformatf("ar_new_src%0d", e), 64'(a_ssrc), 64'(0));
            chk($sformatf("ar_new_last%0d", e), 64'(a_slast), 64'(e == 3));
            @(negedge clk);
        end
        #1;
        chk("ar_no_leftover", 64'(a_sval), 64'(0));

        // --- throughput with both ports continuously valid
        do_reset();
        set_a_msgs(32'h10, 32'hA0);
        a_val = 2'b11; a_srdy = 1'b1;
        first_acc = -1; last_cyc = -1; nwords = 0; gaps = 0;
        for (int cyc = 0; cyc < 40 && nwords < 8; cyc++) begin
            #1;
            if (first_acc < 0 && a_rdy != 0) first_acc = cyc;
            if (a_sval) begin
                chk($sformatf("tp_msg%0d", nwords), 64'(a_smsg),
                    64'((nwords < 4 ? 32'h10 : 32'hA0) + (nwords % 4)));
                chk($sformatf("tp_src%0d", nwords), 64'(a_ssrc), 64'(nwords / 4));
                chk($sformatf("tp_last%0d", nwords), 64'(a_slast), 64'(nwords % 4 == 3));
                nwords++;
                last_cyc = cyc;
            end else if (first_acc >= 0 && first_acc != cyc) begin
                gaps++;
            end
            @(negedge clk);
        end
        a_val = '0;
`ifdef ARB_SERIALIZER_2D_B2B_EN
        exp_span = 8; exp_gaps = 0;
`else
        exp_span = 9; exp_gaps = 1;
`endif
        chk("tp_words", 64'(nwords), 64'(8));
        chk("tp_span", 64'(last_cyc - first_acc), 64'(exp_span));
        chk("tp_gaps", 64'(gaps), 64'(exp_gaps));

        // --- N=3, ENTRIES=1, ports 0 and 2: alternate with pointer wrap
        do_reset();
        b_val = 3'b101; b_srdy = 1'b1;
        nwords = 0; saw_bad = 1'b0;
        for (int cyc = 0; cyc < 30 && nwords < 4; cyc++) begin
            #1;
            if (b_rdy[1]) saw_bad = 1'b1;
            if (b_sval) begin
                exp_src = (nwords % 2 == 1) ? 2'd2 : 2'd0;
                chk($sformatf("b_src%0d", nwords), 64'(b_ssrc), 64'(exp_src));
                chk($sformatf("b_last%0d", nwords), 64'(b_slast), 64'(1));
                chk($sformatf("b_msg%0d", nwords), 64'(b_smsg), 64'(32'h300 + exp_src));
                nwords++;
            end
            @(negedge clk);
        end
        b_val = '0;
        chk("b_words", 64'(nwords), 64'(4));
        chk("b_port1_never_ready", 64'(saw_bad), 64'(0));

        // --- randomized run on N=3, ENTRIES=3 against the queue model
        do_reset();
        random_run(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_serializer_2d.md
Name: arb_serializer_2d

Overview:
- Many-to-one consumer of 2-d array ports: the draining end of crossbar_2d send ports.
- Round-robin arbitrates among N_INPUTS ports, each carrying ENTRIES words of BIT_WIDTH.
- Captures the winning array whole, then streams its entries one word per handshake on a single val/rdy output.
- Tags each word with its source port and a last-entry flag; feeds narrow consumers (FFT, memory writers) downstream of the crossbars.

Parameters:
- BIT_WIDTH, 32, width of each entry word.
- N_INPUTS, 2, number of 2-d input ports; legal range 2 or more.
- ENTRIES, 2, entries per input port; legal range 1 or more.
- SRC_W (localparam), $clog2(N_INPUTS), width of the source tag.
- CNT_W (localparam), max(1,$clog2(ENTRIES)), width of the entry counter.

Ports:
- clk  in  1  clock, single domain.
- reset  in  1  asynchronous, active-high reset.
- recv_msg  in  [BIT_WIDTH-1:0] [N_INPUTS][ENTRIES]  input arrays.
- recv_val  in  1 [N_INPUTS]  per-port valid.
- recv_rdy  out  1 [N_INPUTS]  per-port ready.
- send_msg  out  BIT_WIDTH  current entry word.
- send_val  out  1  output valid.
- send_rdy  in  1  output ready.
- send_src  out  SRC_W  index of the input port being drained.
- send_last  out  1  high on entry ENTRIES-1.

Behaviour:
- Handshakes: a transfer fires when val and rdy are both high at posedge clk. send_val does not depend combinationally on send_rdy. recv_rdy depends combinationally on recv_val, through the arbiter only.
- FSM has two states, IDLE and BUSY.
- Registers: state, prio_ptr (SRC_W), buf [ENTRIES] words, src_q, cnt (CNT_W).
- Reset, asynchronous and applied immediately: state=IDLE, prio_ptr=0, cnt=0, src_q=0, buf all 0.
  - Outputs during reset: send_val=0, all recv_rdy=0, send_msg=0, send_src=0, send_last=0.
  - Reset mid-packet discards the remaining entries; no partial packet resumes.
- IDLE:
  - send_val=0.
  - grant = first i with recv_val[i]=1, scanning prio_ptr, prio_ptr+1, … mod N_INPUTS.
  - recv_rdy[grant]=1 if any valid; every other recv_rdy=0.
  - On fire: buf <= recv_msg[grant][*], src_q <= grant, cnt <= 0, prio_ptr <= (grant+1) mod N_INPUTS, state <= BUSY.
  - No valid input: hold all state.
- BUSY:
  - All recv_rdy=0. send_val=1, send_msg=buf[cnt], send_src=src_q, send_last=(cnt==ENTRIES-1).
  - Send fire with send_last=0: cnt++.
  - Send fire with send_last=1: state <= IDLE, cnt <= 0.
  - send_rdy=0: all outputs held stable.
- Latency: array accepted at edge t; entry 0 valid in cycle t+1.
- Throughput: one packet per ENTRIES+1 cycles (base build).
- Wrap: prio_ptr wraps N_INPUTS-1 -> 0, including non-power-of-two N_INPUTS. cnt never exceeds ENTRIES-1.
- ENTRIES=1: every word has send_last=1; packet occupies one BUSY cycle.
- recv_msg of an ungranted port is ignored. A port dropping recv_val without a fire is legal and loses nothing.
- Starvation-free: a continuously valid port is granted within N_INPUTS packets.

Optional Feature:
- Macro: ARB_SERIALIZER_2D_B2B_EN.
- Defined:
  - In BUSY, while send_last=1 and send_rdy=1, the arbiter runs exactly as in IDLE.
  - A winning recv fire in that cycle loads buf/src_q/cnt=0 and stays in BUSY.
  - Throughput becomes one packet per ENTRIES cycles; no idle gap between packets.
- Undefined: base behaviour above; recv_rdy is never high in BUSY.

Decomposition:
- Package arb_serializer_2d_pkg holds:
  - the state enum (IDLE, BUSY);
  - the round-robin next-grant function (ptr, val vector) -> grant, any.
- One sub-module: rr_arbiter, parameterized by N_INPUTS.
  - Inputs: req vector, prio_ptr, en.
  - Outputs: one-hot grant, grant index, any.
- Top holds the FSM, buffer and counter.

Test Plan:
- N_INPUTS=2, ENTRIES=4, only port1 valid with {A0,A1,A2,A3}, send_rdy=1 -> recv_rdy[1] high one cycle. Next 4 cycles send A0..A3 with send_src=1 and send_last only on A3. recv_rdy low throughout BUSY. Next packet accepted 5 cycles after the first.
- Both ports valid continuously, prio_ptr=0 after reset -> grant order 0,1,0,1. send_src sequence per packet is 0,1,0,1.
- send_rdy toggled 1,0,0,1 mid-packet -> send_msg/send_src/send_last stable while stalled. Exactly ENTRIES words delivered in order, none duplicated.
- Assert reset asynchronously after entry 1 of a 4-entry packet -> outputs zero immediately, without waiting for a clock edge. After release, a new packet from port0 streams from entry 0.
- ENTRIES=1, N_INPUTS=3, ports 0 and 2 valid -> words alternate 0,2,0,2, each with send_last=1. prio_ptr wraps from 2 to 0.
- With ARB_SERIALIZER_2D_B2B_EN, ENTRIES=4, back-to-back valid packets -> send_val high continuously; 8 words in 8 cycles after the first accept.
